// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: valid/ready bundle between N input streams and one registered output stream
// slave  : DUT view (mode/sel/in_valid/in_data/out_ready in; in_ready/out_valid/out_data/out_ch/beat_cnt out)
// master : source/sink view, directions mirrored
interface stream_mux_rr_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_ready;
    logic [CNT_W-1:0]         beat_cnt;
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, beat_cnt
    );
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, beat_cnt
    );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream mux, explicit select or round-robin, one output stage
// clk : rising-edge clock
// rst : synchronous active-high reset
// bus : stream_mux_rr_if.slave (inputs mode, sel, in_valid, in_data, out_ready;
//       outputs in_ready, out_valid, out_data, out_ch, beat_cnt)
module stream_mux_rr #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input logic           clk,
    input logic           rst,
    stream_mux_rr_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t              r_state, w_state_n;
    logic [SEL_W-1:0]    r_last_grant, r_ch, w_rr_grant, w_grant;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_rr_valid, w_sel_valid, w_grant_valid, w_load_en, w_xfer_in, w_xfer_out;
    // Scan from the lowest priority (last_grant itself) to the highest so the
    // final assignment is the first valid channel after last_grant.
    always_comb begin
        w_rr_valid = 1'b0;
        w_rr_grant = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (bus.in_valid[(int'(r_last_grant) + k) % NUM_CH]) begin
                w_rr_valid = 1'b1;
                w_rr_grant = SEL_W'((int'(r_last_grant) + k) % NUM_CH);
            end
        end
    end
    assign w_sel_valid   = (int'(bus.sel) < NUM_CH) ? bus.in_valid[bus.sel] : 1'b0;
    assign w_grant       = bus.mode ? w_rr_grant : bus.sel;
    assign w_grant_valid = bus.mode ? w_rr_valid : w_sel_valid;
    assign w_load_en     = (r_state == EMPTY) || bus.out_ready;
    assign bus.in_ready  = (w_load_en && w_grant_valid && !rst) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_grant) : '0;
    assign w_xfer_in     = |(bus.in_valid & bus.in_ready);
    assign w_xfer_out    = (r_state == FULL) && bus.out_ready;
    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_n;
    end
    // An incoming beat wins over a pop, so a simultaneous in/out stays FULL.
    always_comb begin
        w_state_n = w_xfer_in ? FULL : (w_xfer_out ? EMPTY : r_state);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= '0;
            r_ch         <= '0;
            r_cnt        <= '0;
            r_last_grant <= SEL_W'(NUM_CH - 1);
        end else if (w_xfer_in) begin
            r_data       <= bus.in_data[int'(w_grant)*DATA_W +: DATA_W];
            r_ch         <= w_grant;
            r_cnt        <= r_cnt + 1'b1;
            r_last_grant <= w_grant;
        end
    end
    assign bus.out_valid = (r_state == FULL);
    assign bus.out_data  = r_data;
    assign bus.out_ch    = r_ch;
    assign bus.beat_cnt  = r_cnt;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for stream_mux_rr with a queue-based reference model
module tb_stream_mux_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    stream_mux_rr_if #(.NUM_CH(4), .DATA_W(4), .SEL_W(2), .CNT_W(16)) b ();
    stream_mux_rr_if #(.NUM_CH(5), .DATA_W(3), .SEL_W(3), .CNT_W(8))  b5 ();
    stream_mux_rr #(.NUM_CH(4), .DATA_W(4), .SEL_W(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(b.slave));
    stream_mux_rr #(.NUM_CH(5), .DATA_W(3), .SEL_W(3), .CNT_W(8))  dut5 (.clk(clk), .rst(rst), .bus(b5.slave));
    typedef struct {
        int unsigned ch;
        int unsigned data;
    } beat_t;
    beat_t q[$];
    bit m_full = 0;
    int unsigned m_last = 3;
    int unsigned m_cnt = 0;
    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // One cycle of stimulus; the model decides from the rules which channel
    // (if any) must be accepted and what the output register will then hold.
    task automatic step(input bit m, input int unsigned s, input logic [3:0] v, input logic [15:0] d, input bit rdy);
        bit gv;
        int unsigned g;
        bit load;
        @(negedge clk);
        b.mode = m;
        b.sel = 2'(s);
        b.in_valid = v;
        b.in_data = d;
        b.out_ready = rdy;
        #1;
        chk("out_valid", b.out_valid, m_full);
        chk("beat_cnt", b.beat_cnt, m_cnt & 16'hFFFF);
        gv = 0;
        g = 0;
        if (!m) begin
            g = s;
            gv = (s < 4) && v[s];
        end else begin
            for (int k = 1; k <= 4 && !gv; k++) begin
                if (v[(m_last + k) % 4]) begin
                    gv = 1;
                    g = (m_last + k) % 4;
                end
            end
        end
        load = !m_full || rdy;
        chk("in_ready", b.in_ready, (load && gv) ? (1 << g) : 0);
        if (load && gv) begin
            q.push_back('{ch: g, data: (d >> (g*4)) & 4'hF});
            m_full = 1;
            m_last = g;
            m_cnt++;
        end else if (m_full && rdy) begin
            m_full = 0;
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        b.out_ready = 0;
        b.mode = 1;
        b.in_valid = 4'hF;
        #1;
        chk("in_ready_in_rst", b.in_ready, 0);
        @(negedge clk);
        b.in_valid = 4'h0;
        rst = 0;
        q.delete();
        m_full = 0;
        m_last = 3;
        m_cnt = 0;
        #1;
        chk("rst_out_valid", b.out_valid, 0);
        chk("rst_beat_cnt", b.beat_cnt, 0);
        chk("rst_out_data", b.out_data, 0);
        chk("rst_out_ch", b.out_ch, 0);
    endtask
    // Monitor: whenever a beat is held it must match the oldest expected beat;
    // it is retired when the downstream handshake completes.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && b.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("out_data", b.out_data, q[0].data);
                    chk("out_ch", b.out_ch, q[0].ch);
                    if (b.out_ready) void'(q.pop_front());
                end
            end
        end
    end
    initial begin
        b.mode = 0; b.sel = 0; b.in_valid = 0; b.in_data = 0; b.out_ready = 0;
        b5.mode = 0; b5.sel = 0; b5.in_valid = 0; b5.in_data = 0; b5.out_ready = 0;
        repeat (2) @(posedge clk);
        do_reset();
        step(0, 2, 4'b0100, 16'h0A00, 1);
        step(0, 1, 4'b1101, 16'h5A3C, 1);
        step(0, 1, 4'b1101, 16'h1234, 1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 4'hF, 16'(i * 16'h1111 + 16'h0123), 1);
        step(1, 0, 4'b1001, 16'h7BC5, 1);
        step(1, 0, 4'b1001, 16'h6EE2, 1);
        step(1, 0, 4'hF, 16'hC0DE, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 4'hF, 16'hC0DE, 0);
        step(1, 0, 4'hF, 16'hC0DE, 1);
        step(1, 0, 4'hF, 16'h9876, 0);
        do_reset();
        step(1, 0, 4'hF, 16'h4321, 1);
        for (int i = 0; i < 400; i++)
            step(1'($urandom), $urandom_range(0, 3), 4'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 16'h0, 1);
        chk("queue_drained", q.size(), 0);
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            b5.mode = 0;
            b5.sel = 3'(s);
            b5.in_valid = 5'h1F;
            b5.in_data = 15'($urandom);
            b5.out_ready = 1;
            #1;
            chk("sel_range5", b5.in_ready, (s < 5) ? (1 << s) : 0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b5.mode = 1;
            #1;
            chk("rr5", b5.in_ready, 1 << (i % 5));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
